// File: rtl/mux_scan_ctrl.sv
// Scan controller for mux_4x1: steps the select through enabled channels, samples after a settle time, emits a 4-bit frame.
// Optional MUX_SCAN_CHANGE_DET_EN adds a frame_changed pulse alongside frame_valid.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] ch_mask,
  input  logic       mux_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
`ifdef MUX_SCAN_CHANGE_DET_EN
  output logic       frame_changed,
`endif
  output logic [7:0] frame_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CH_N   = 4;
  localparam int unsigned FCNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CH_N-1:0]   shadow;
  logic [CH_N-1:0]   mask_q;
  logic [2:0]        next_sel;
  logic [CH_N-1:0]   new_frame;

  // Lowest set bit of the mask; callers guarantee a non-zero mask.
  function automatic logic [1:0] lowest_ch(input logic [CH_N-1:0] m);
    lowest_ch = 2'd0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = 2'(i);
    end
  endfunction

  // {found, index} of the next enabled channel strictly above cur.
  function automatic logic [2:0] next_ch(input logic [CH_N-1:0] m, input logic [1:0] cur);
    next_ch = 3'b000;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (m[i] && (2'(i) > cur)) next_ch = {1'b1, 2'(i)};
    end
  endfunction

  assign next_sel  = next_ch(mask_q, sel);
  assign new_frame = shadow & mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= 2'd0;
      busy          <= 1'b0;
      frame         <= '0;
      frame_valid   <= 1'b0;
      frame_cnt     <= '0;
      shadow        <= '0;
      mask_q        <= '0;
      cnt           <= '0;
`ifdef MUX_SCAN_CHANGE_DET_EN
      frame_changed <= 1'b0;
`endif
    end else begin
      frame_valid   <= 1'b0;
`ifdef MUX_SCAN_CHANGE_DET_EN
      frame_changed <= 1'b0;
`endif
      case (state)
        IDLE: begin
          sel  <= 2'd0;
          busy <= 1'b0;
          if (start && (ch_mask != '0)) begin
            mask_q <= ch_mask;
            shadow <= '0;
            sel    <= lowest_ch(ch_mask);
            cnt    <= CNT_LOAD;
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end

        SAMPLE: begin
          shadow[sel] <= mux_in;
          if (next_sel[2]) begin
            sel   <= next_sel[1:0];
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end else begin
            state <= DONE;
          end
        end

        DONE: begin
          frame       <= new_frame;
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + FCNT_W'(1);
`ifdef MUX_SCAN_CHANGE_DET_EN
          frame_changed <= (new_frame != frame);
`endif
          // Continuous mode re-arms from the live mask without passing through IDLE.
          if (cont && (ch_mask != '0)) begin
            mask_q <= ch_mask;
            shadow <= '0;
            sel    <= lowest_ch(ch_mask);
            cnt    <= CNT_LOAD;
            state  <= SETTLE;
          end else begin
            sel   <= 2'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (settle 1 and 2), each fed by a behavioural mux_4x1.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       cont;
  logic [3:0] ch_mask;
  logic [3:0] i_val;
  logic       mux_a, mux_b;
  logic [1:0] sel_a, sel_b;
  logic       busy_a, busy_b;
  logic [3:0] frame_a, frame_b;
  logic       fv_a, fv_b;
  logic [7:0] cnt_a, cnt_b;
`ifdef MUX_SCAN_CHANGE_DET_EN
  logic       fc_a, fc_b;
`endif

  logic       start;
  logic       use_b;
  logic [1:0] cur_sel;
  logic       cur_busy, cur_fv;
  logic [3:0] cur_frame;
  logic [7:0] cur_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_cnt_a = 8'd0;
  logic [7:0] exp_cnt_b = 8'd0;

  always #5 clk = ~clk;

  assign mux_a   = i_val[sel_a];
  assign mux_b   = i_val[sel_b];
  assign start_a = start & ~use_b;
  assign start_b = start & use_b;

  assign cur_sel   = use_b ? sel_b   : sel_a;
  assign cur_busy  = use_b ? busy_b  : busy_a;
  assign cur_fv    = use_b ? fv_b    : fv_a;
  assign cur_frame = use_b ? frame_b : frame_a;
  assign cur_cnt   = use_b ? cnt_b   : cnt_a;

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont(cont), .ch_mask(ch_mask),
    .mux_in(mux_a), .sel(sel_a), .busy(busy_a), .frame(frame_a),
    .frame_valid(fv_a),
`ifdef MUX_SCAN_CHANGE_DET_EN
    .frame_changed(fc_a),
`endif
    .frame_cnt(cnt_a)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(cont), .ch_mask(ch_mask),
    .mux_in(mux_b), .sel(sel_b), .busy(busy_b), .frame(frame_b),
    .frame_valid(fv_b),
`ifdef MUX_SCAN_CHANGE_DET_EN
    .frame_changed(fc_b),
`endif
    .frame_cnt(cnt_b)
  );

  typedef struct {
    bit         use_b;
    logic [3:0] mask;
    logic [3:0] iv;
    logic [3:0] ef;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One single-shot frame; poke re-pulses start while busy and in DONE.
  task automatic run_frame(input bit b, input logic [3:0] m, input logic [3:0] iv,
                           input logic [3:0] ef, input int el, input bit poke, input string nm);
    int         n;
    logic [3:0] visited;
    logic [1:0] last;
    bit         mono;
    bit         extra;
    logic [7:0] cnt_hold;
    use_b   = b;
    ch_mask = m;
    i_val   = iv;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy"}, 32'(cur_busy), 32'd1);
    n = 0; visited = 4'b0; mono = 1'b1; last = cur_sel;
    while (!cur_fv && n < 60) begin
      if (cur_busy) begin
        visited[cur_sel] = 1'b1;
        if (cur_sel < last) mono = 1'b0;
        last = cur_sel;
      end
      @(negedge clk);
      n++;
      start = poke && (n == 3 || n == 8);
    end
    start = 1'b0;
    if (b) exp_cnt_b = exp_cnt_b + 8'd1;
    else   exp_cnt_a = exp_cnt_a + 8'd1;
    chk({nm, "_latency"}, 32'(n), 32'(el));
    chk({nm, "_frame"}, 32'(cur_frame), 32'(ef));
    chk({nm, "_sel_visits"}, 32'(visited), 32'(m));
    chk({nm, "_sel_order"}, 32'(mono), 32'd1);
    chk({nm, "_cnt"}, 32'(cur_cnt), 32'(b ? exp_cnt_b : exp_cnt_a));
    @(negedge clk);
    chk({nm, "_fv_drop"}, 32'(cur_fv), 32'd0);
    chk({nm, "_idle_busy"}, 32'(cur_busy), 32'd0);
    chk({nm, "_idle_sel"}, 32'(cur_sel), 32'd0);
    chk({nm, "_frame_hold"}, 32'(cur_frame), 32'(ef));
    if (poke) begin
      extra = 1'b0;
      cnt_hold = cur_cnt;
      repeat (15) begin
        @(negedge clk);
        if (cur_fv || cur_busy) extra = 1'b1;
      end
      chk({nm, "_no_extra_frame"}, 32'(extra), 32'd0);
      chk({nm, "_cnt_unchanged"}, 32'(cur_cnt), 32'(cnt_hold));
    end
  endtask

  initial begin
    int         n, frames, since;
    int         bad_int, busy_drop, bad_frame, bad_cnt, bad_ch;
    bit         seen;
    logic [3:0] exp_f;
    logic [7:0] cnt_at_256;

    vecs[0] = '{1'b0, 4'b1111, 4'b1010, 4'b1010, 9};
    vecs[1] = '{1'b1, 4'b0101, 4'b1111, 4'b0101, 7};
    vecs[2] = '{1'b0, 4'b0101, 4'b1111, 4'b0101, 5};
    vecs[3] = '{1'b0, 4'b1000, 4'b1111, 4'b1000, 3};
    vecs[4] = '{1'b0, 4'b0110, 4'b0100, 4'b0100, 5};
    vecs[5] = '{1'b0, 4'b1001, 4'b0110, 4'b0000, 5};
    vecs[6] = '{1'b0, 4'b0011, 4'b1101, 4'b0001, 5};
    vecs[7] = '{1'b1, 4'b1010, 4'b0110, 4'b0010, 7};

    rst = 1'b1; start = 1'b0; use_b = 1'b0; cont = 1'b0;
    ch_mask = 4'b0000; i_val = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_sel_a", 32'(sel_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_frame_a", 32'(frame_a), 32'd0);
    chk("rst_fv_a", 32'(fv_a), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].use_b, vecs[v].mask, vecs[v].iv, vecs[v].ef, vecs[v].lat,
                1'b0, $sformatf("vec%0d", v));
    end

    // Reset while settling channel 2 discards the partial frame.
    use_b = 1'b0; ch_mask = 4'b1111; i_val = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_pre_sel", 32'(sel_a), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt_a = 8'd0;
    chk("midrst_sel", 32'(sel_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_frame", 32'(frame_a), 32'd0);
    chk("midrst_cnt", 32'(cnt_a), 32'd0);
    chk("midrst_fv", 32'(fv_a), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (fv_a) seen = 1'b1;
    end
    chk("midrst_no_fv", 32'(seen), 32'd0);
    run_frame(1'b0, 4'b1111, 4'b1010, 4'b1010, 9, 1'b0, "post_rst");

    // start pulses while busy / in DONE are ignored.
    run_frame(1'b0, 4'b1111, 4'b0011, 4'b0011, 9, 1'b1, "busy_start");

    // start with an all-zero mask is ignored.
    ch_mask = 4'b0000;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (fv_a || busy_a) seen = 1'b1;
    end
    chk("zero_mask_ignored", 32'(seen), 32'd0);
    chk("zero_mask_cnt", 32'(cnt_a), 32'(exp_cnt_a));

    // Continuous mode: 256 back-to-back frames, input changes after frame 100.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    use_b = 1'b0; ch_mask = 4'b1111; i_val = 4'b0110; cont = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    frames = 0; n = 0; since = 0;
    bad_int = 0; busy_drop = 0; bad_frame = 0; bad_cnt = 0; bad_ch = 0;
    cnt_at_256 = 8'hxx;
    while (frames < 256 && n < 256 * 9 + 50) begin
      @(negedge clk);
      n++;
      since++;
      if (!busy_a) busy_drop++;
      if (fv_a) begin
        frames++;
        exp_f = (frames > 100) ? 4'b0111 : 4'b0110;
        if (frame_a != exp_f) bad_frame++;
        if (since != 9) bad_int++;
        if (cnt_a != 8'(frames)) bad_cnt++;
`ifdef MUX_SCAN_CHANGE_DET_EN
        if (fc_a != ((frames == 1) || (frames == 101))) bad_ch++;
`endif
        if (frames == 100) i_val = 4'b0111;
        if (frames == 256) cnt_at_256 = cnt_a;
        since = 0;
      end else begin
`ifdef MUX_SCAN_CHANGE_DET_EN
        if (fc_a) bad_ch++;
`endif
      end
    end
    chk("cont_frames", 32'(frames), 32'd256);
    chk("cont_interval_errs", 32'(bad_int), 32'd0);
    chk("cont_busy_drops", 32'(busy_drop), 32'd0);
    chk("cont_frame_errs", 32'(bad_frame), 32'd0);
    chk("cont_cnt_errs", 32'(bad_cnt), 32'd0);
    chk("cont_cnt_wrap", 32'(cnt_at_256), 32'd0);
`ifdef MUX_SCAN_CHANGE_DET_EN
    chk("cont_changed_errs", 32'(bad_ch), 32'd0);
`endif
    cont = 1'b0;
    n = 0;
    while (busy_a && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("cont_stop_busy", 32'(busy_a), 32'd0);
    chk("cont_stop_cnt", 32'(cnt_a), 32'd1);
    chk("cont_stop_frame", 32'(frame_a), 32'b0111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
